// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared constants for the RV32 core slice: datapath width, instruction size,
// the canonical bubble instruction and the fixed reset / trap vectors.
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int INSTR_BYTES = 4;

    // addi x0, x0, 0 -- architecturally a no-op, used to fill pipeline bubbles.
    localparam logic [DATA_WIDTH-1:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h0040_0000;
    localparam logic [DATA_WIDTH-1:0] TRAP_VECTOR  = 32'h0040_0100;

    // A target is word-aligned when its two low address bits are zero.
    function automatic logic is_misaligned(input logic [DATA_WIDTH-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage : riscv_pkg

// File: rtl/pc_register.sv
// -----------------------------------------------------------------------------
// pc_register
// Program-counter flop with its next-PC mux. Shared by the fetch stage and
// the single-cycle datapath.
//
// Ports:
//   clk               in   rising-edge clock
//   reset             in   synchronous, active-high; loads RESET_VECTOR
//   hold_i            in   keep the current PC (ignored when load_i is high)
//   load_i            in   load load_target_i (or TRAP_VECTOR if misaligned)
//   load_target_i     in   byte address to load
//   pc_o              out  current PC
//   load_misaligned_o out  combinational: load_i is high with a misaligned target
// -----------------------------------------------------------------------------
module pc_register
    import riscv_pkg::*;
#(
    parameter int                    DATA_WIDTH   = riscv_pkg::DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = riscv_pkg::RESET_VECTOR,
    parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR  = riscv_pkg::TRAP_VECTOR
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hold_i,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] load_target_i,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  load_misaligned_o
);

    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pc_d;

    assign load_misaligned_o = load_i && is_misaligned(load_target_i);
    assign pc_o              = pc_q;

    // Load beats hold; a misaligned load is diverted to the trap handler so the
    // PC never carries non-zero low bits.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_misaligned_o ? TRAP_VECTOR : load_target_i;
        end else if (!hold_i) begin
            pc_d = pc_q + DATA_WIDTH'(INSTR_BYTES); // modulo 2^DATA_WIDTH
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // pre-edge values regardless of statement order.
        if (reset) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule : pc_register

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch: owns the PC, addresses program memory, and captures the
// returned instruction (with PC and PC+4) into the IF/ID register. Handles
// stall, redirect with flush, misaligned-target trap, out-of-window fetch
// fault and a count of valid fetches.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   stall_i              hold PC, IF/ID and counter
//   redirect_i           load PC from redirect_target_i, flush IF/ID
//   redirect_target_i    branch/jump target byte address
//   instr_addr_o         byte address to program memory (= PC)
//   instr_i              instruction returned for instr_addr_o
//   if_id_valid_o        IF/ID holds a real instruction
//   if_id_pc_o           PC of the registered instruction
//   if_id_pc_plus4_o     if_id_pc_o + 4
//   if_id_instr_o        registered instruction
//   misalign_trap_o      one-cycle pulse after a misaligned redirect
//   fetch_fault_o        sticky: a fetch was attempted outside the window
//   fetch_count_o        number of valid instructions written into IF/ID
// -----------------------------------------------------------------------------
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = riscv_pkg::RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR  = riscv_pkg::TRAP_VECTOR,
    parameter int          MEMORY_DEPTH = 32,
    parameter int          DATA_WIDTH   = riscv_pkg::DATA_WIDTH,
    parameter logic [31:0] NOP_INSTR    = riscv_pkg::NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_target_i,
    output logic [DATA_WIDTH-1:0] instr_addr_o,
    input  logic [DATA_WIDTH-1:0] instr_i,
    output logic                  if_id_valid_o,
    output logic [DATA_WIDTH-1:0] if_id_pc_o,
    output logic [DATA_WIDTH-1:0] if_id_pc_plus4_o,
    output logic [DATA_WIDTH-1:0] if_id_instr_o,
    output logic                  misalign_trap_o,
    output logic                  fetch_fault_o,
    output logic [DATA_WIDTH-1:0] fetch_count_o
);

    localparam logic [DATA_WIDTH-1:0] WINDOW_BASE = DATA_WIDTH'(RESET_VECTOR);
    localparam logic [DATA_WIDTH-1:0] WINDOW_END  =
        DATA_WIDTH'(RESET_VECTOR) + DATA_WIDTH'(INSTR_BYTES * MEMORY_DEPTH);
    localparam logic [DATA_WIDTH-1:0] PC_STEP     = DATA_WIDTH'(INSTR_BYTES);

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] pc_plus4;
        logic [DATA_WIDTH-1:0] instr;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{
        valid:    1'b0,
        pc:       '0,
        pc_plus4: '0,
        instr:    DATA_WIDTH'(NOP_INSTR)
    };

    logic [DATA_WIDTH-1:0] pc;
    logic                  redirect_misaligned;
    logic                  pc_in_window;

    if_id_t                if_id_q, if_id_d;
    logic                  trap_q, trap_d;
    logic                  fault_q, fault_d;
    logic [DATA_WIDTH-1:0] count_q, count_d;

    pc_register #(
        .DATA_WIDTH   (DATA_WIDTH),
        .RESET_VECTOR (DATA_WIDTH'(RESET_VECTOR)),
        .TRAP_VECTOR  (DATA_WIDTH'(TRAP_VECTOR))
    ) u_pc_register (
        .clk               (clk),
        .reset             (reset),
        .hold_i            (stall_i),
        .load_i            (redirect_i),
        .load_target_i     (redirect_target_i),
        .pc_o              (pc),
        .load_misaligned_o (redirect_misaligned)
    );

    assign pc_in_window = (pc >= WINDOW_BASE) && (pc < WINDOW_END);

    always_comb begin
        if_id_d = if_id_q;
        trap_d  = 1'b0;     // the trap flag is a single-cycle pulse
        fault_d = fault_q;  // sticky until reset
        count_d = count_q;

        if (redirect_i) begin
            if_id_d = IF_ID_BUBBLE;
            trap_d  = redirect_misaligned;
        end else if (!stall_i) begin
            if (pc_in_window) begin
                if_id_d = '{valid: 1'b1, pc: pc, pc_plus4: pc + PC_STEP, instr: instr_i};
                count_d = count_q + DATA_WIDTH'(1);
            end else begin
                // Out-of-window fetch: drop the returned word, keep advancing.
                if_id_d = IF_ID_BUBBLE;
                fault_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_q <= IF_ID_BUBBLE;
            trap_q  <= 1'b0;
            fault_q <= 1'b0;
            count_q <= '0;
        end else begin
            if_id_q <= if_id_d;
            trap_q  <= trap_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    assign instr_addr_o     = pc;
    assign if_id_valid_o    = if_id_q.valid;
    assign if_id_pc_o       = if_id_q.pc;
    assign if_id_pc_plus4_o = if_id_q.pc_plus4;
    assign if_id_instr_o    = if_id_q.instr;
    assign misalign_trap_o  = trap_q;
    assign fetch_fault_o    = fault_q;
    assign fetch_count_o    = count_q;

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage. Program memory is modelled as
// instr = 0xA500_0000 ^ address, so every expected instruction is a constant
// written in the table below.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_target_i;
    logic [31:0] instr_addr_o;
    logic [31:0] instr_i;
    logic        if_id_valid_o;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_pc_plus4_o;
    logic [31:0] if_id_instr_o;
    logic        misalign_trap_o;
    logic        fetch_fault_o;
    logic [31:0] fetch_count_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign instr_i = 32'hA500_0000 ^ instr_addr_o;

    fetch_stage dut (
        .clk               (clk),
        .reset             (reset),
        .stall_i           (stall_i),
        .redirect_i        (redirect_i),
        .redirect_target_i (redirect_target_i),
        .instr_addr_o      (instr_addr_o),
        .instr_i           (instr_i),
        .if_id_valid_o     (if_id_valid_o),
        .if_id_pc_o        (if_id_pc_o),
        .if_id_pc_plus4_o  (if_id_pc_plus4_o),
        .if_id_instr_o     (if_id_instr_o),
        .misalign_trap_o   (misalign_trap_o),
        .fetch_fault_o     (fetch_fault_o),
        .fetch_count_o     (fetch_count_o)
    );

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] target;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        trap;
        logic        fault;
        logic [31:0] count;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, " addr"},  instr_addr_o,            v.addr);
        check({tag, " valid"}, {31'b0, if_id_valid_o},  {31'b0, v.valid});
        check({tag, " pc"},    if_id_pc_o,              v.pc);
        check({tag, " pc4"},   if_id_pc_plus4_o,        v.pc4);
        check({tag, " instr"}, if_id_instr_o,           v.instr);
        check({tag, " trap"},  {31'b0, misalign_trap_o}, {31'b0, v.trap});
        check({tag, " fault"}, {31'b0, fetch_fault_o},  {31'b0, v.fault});
        check({tag, " count"}, fetch_count_o,           v.count);
    endtask

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] t,
                                input logic [31:0] a, input logic v, input logic [31:0] p,
                                input logic [31:0] p4, input logic [31:0] i,
                                input logic tr, input logic f, input logic [31:0] c);
        vec_t x;
        x.stall = s; x.redirect = r; x.target = t;
        x.addr = a; x.valid = v; x.pc = p; x.pc4 = p4; x.instr = i;
        x.trap = tr; x.fault = f; x.count = c;
        return x;
    endfunction

    // Drive inputs, take one edge, sample 1 time unit later.
    task automatic step(input logic rst, input logic s, input logic r, input logic [31:0] t);
        reset = rst; stall_i = s; redirect_i = r; redirect_target_i = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t rst_v;
        rst_v = mk(0, 0, 0, 32'h0040_0000, 0, 0, 0, NOP, 0, 0, 0);

        //          stall redir target        addr          v  pc            pc4           instr         tr f  cnt
        vecs.push_back(mk(0, 0, 0,            32'h0040_0004, 1, 32'h0040_0000, 32'h0040_0004, 32'hA540_0000, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0,            32'h0040_0008, 1, 32'h0040_0004, 32'h0040_0008, 32'hA540_0004, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0,            32'h0040_000C, 1, 32'h0040_0008, 32'h0040_000C, 32'hA540_0008, 0, 0, 3));
        vecs.push_back(mk(0, 0, 0,            32'h0040_0010, 1, 32'h0040_000C, 32'h0040_0010, 32'hA540_000C, 0, 0, 4));
        // back to 0x08, then stall there for three cycles
        vecs.push_back(mk(0, 1, 32'h0040_0008, 32'h0040_0008, 0, 0, 0, NOP, 0, 0, 4));
        vecs.push_back(mk(1, 0, 0,            32'h0040_0008, 0, 0, 0, NOP, 0, 0, 4));
        vecs.push_back(mk(1, 0, 0,            32'h0040_0008, 0, 0, 0, NOP, 0, 0, 4));
        vecs.push_back(mk(1, 0, 0,            32'h0040_0008, 0, 0, 0, NOP, 0, 0, 4));
        vecs.push_back(mk(0, 0, 0,            32'h0040_000C, 1, 32'h0040_0008, 32'h0040_000C, 32'hA540_0008, 0, 0, 5));
        vecs.push_back(mk(0, 0, 0,            32'h0040_0010, 1, 32'h0040_000C, 32'h0040_0010, 32'hA540_000C, 0, 0, 6));
        // redirect wins over stall
        vecs.push_back(mk(1, 1, 32'h0040_0040, 32'h0040_0040, 0, 0, 0, NOP, 0, 0, 6));
        vecs.push_back(mk(0, 0, 0,            32'h0040_0044, 1, 32'h0040_0040, 32'h0040_0044, 32'hA540_0040, 0, 0, 7));
        // misaligned target: trap pulse, then low again during a stall
        vecs.push_back(mk(0, 1, 32'h0040_0042, 32'h0040_0100, 0, 0, 0, NOP, 1, 0, 7));
        vecs.push_back(mk(1, 0, 0,            32'h0040_0100, 0, 0, 0, NOP, 0, 0, 7));
        vecs.push_back(mk(0, 1, 32'h0040_0000, 32'h0040_0000, 0, 0, 0, NOP, 0, 0, 7));
        vecs.push_back(mk(0, 0, 0,            32'h0040_0004, 1, 32'h0040_0000, 32'h0040_0004, 32'hA540_0000, 0, 0, 8));
        // first address past the window: fault sets, count freezes, PC advances
        vecs.push_back(mk(0, 1, 32'h0040_0080, 32'h0040_0080, 0, 0, 0, NOP, 0, 0, 8));
        vecs.push_back(mk(0, 0, 0,            32'h0040_0084, 0, 0, 0, NOP, 0, 1, 8));
        vecs.push_back(mk(0, 0, 0,            32'h0040_0088, 0, 0, 0, NOP, 0, 1, 8));
        vecs.push_back(mk(0, 1, 32'h0040_0000, 32'h0040_0000, 0, 0, 0, NOP, 0, 1, 8));
        vecs.push_back(mk(0, 0, 0,            32'h0040_0004, 1, 32'h0040_0000, 32'h0040_0004, 32'hA540_0000, 0, 1, 9));
        // last legal word is still fetched validly
        vecs.push_back(mk(0, 1, 32'h0040_007C, 32'h0040_007C, 0, 0, 0, NOP, 0, 1, 9));
        vecs.push_back(mk(0, 0, 0,            32'h0040_0080, 1, 32'h0040_007C, 32'h0040_0080, 32'hA540_007C, 0, 1, 10));

        // Reset state
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check_all("reset", rst_v);

        foreach (vecs[i]) begin
            step(0, vecs[i].stall, vecs[i].redirect, vecs[i].target);
            check_all($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset during a misaligned redirect + stall: no trap, all reset values.
        step(1, 1, 1, 32'h0040_0042);
        check_all("rst_mid_redirect", rst_v);
        step(0, 1, 0, 0);
        check_all("rst_after_hold", rst_v);

        // Trap vector sits outside the window: advancing from it raises the fault.
        step(0, 0, 1, 32'h0040_0003);
        check_all("trap_redirect", mk(0, 0, 0, 32'h0040_0100, 0, 0, 0, NOP, 1, 0, 0));
        step(0, 0, 0, 0);
        check_all("trap_fetch", mk(0, 0, 0, 32'h0040_0104, 0, 0, 0, NOP, 0, 1, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_stage
